// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronise, glitch-filter, Gray-decode into
// STEP/DIR pulses with illegal-transition flagging, and keep a wrapping position.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int POS_W       = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             A,
  input  logic             B,
  output logic             STEP,
  output logic             DIR,
  output logic             ERR,
  output logic [POS_W-1:0] POS,
  output logic             CO
);

  localparam int CNT_W    = $clog2(FILT_LEN + 1);
  localparam int INIT_CYC = SYNC_STAGES + FILT_LEN;
  localparam int ICNT_W   = $clog2(INIT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FILT_LEN - 1);
  localparam logic [ICNT_W-1:0] INIT_LAST = ICNT_W'(INIT_CYC - 1);

  typedef enum logic {INIT = 1'b0, TRACK = 1'b1} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             synced;
  logic [1:0]             acc;
  logic [CNT_W-1:0]       cnt [2];
  logic [ICNT_W-1:0]      init_cnt;
  logic                   init_done;
  logic [1:0]             prev;
  logic                   fwd, bwd, illegal;

  // Channel order in every 2-bit vector is {A, B}.
  assign synced    = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign init_done = (state == INIT) && (init_cnt == INIT_LAST);

  function automatic logic [1:0] gray_next(input logic [1:0] g);
    case (g)
      2'b00:   gray_next = 2'b01;
      2'b01:   gray_next = 2'b11;
      2'b11:   gray_next = 2'b10;
      default: gray_next = 2'b00;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], A};
      sync_b <= {sync_b[SYNC_STAGES-2:0], B};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT && !init_done)
        init_cnt <= init_cnt + ICNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    fwd        = 1'b0;
    bwd        = 1'b0;
    illegal    = 1'b0;
    case (state)
      INIT: begin
        if (init_done)
          state_next = TRACK;
      end
      TRACK: begin
        fwd     = (acc == gray_next(prev));
        bwd     = (prev == gray_next(acc));
        illegal = ((acc ^ prev) == 2'b11);
      end
    endcase
  end

  // Once the pipeline has filled, the filter is bypassed so tracking starts
  // from the real pin levels rather than from the reset value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc <= 2'b00;
      for (int i = 0; i < 2; i++)
        cnt[i] <= '0;
    end else if (init_done) begin
      acc <= synced;
      for (int i = 0; i < 2; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] != acc[i]) begin
          if (cnt[i] == CNT_MAX) begin
            acc[i] <= synced[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev <= 2'b00;
      STEP <= 1'b0;
      ERR  <= 1'b0;
      CO   <= 1'b0;
      DIR  <= 1'b1;
      POS  <= '0;
    end else begin
      STEP <= 1'b0;
      ERR  <= 1'b0;
      CO   <= 1'b0;
      if (state == INIT) begin
        if (init_done)
          prev <= synced;
      end else begin
        prev <= acc;
        if (EN) begin
          if (fwd) begin
            STEP <= 1'b1;
            DIR  <= 1'b1;
            POS  <= POS + POS_W'(1);
            CO   <= &POS;
          end else if (bwd) begin
            STEP <= 1'b1;
            DIR  <= 1'b0;
            POS  <= POS - POS_W'(1);
            CO   <= ~|POS;
          end else if (illegal) begin
            ERR  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random pin activity,
// every cycle scored against a pin-history reference model.
module tb_quad_step_decoder;

  localparam int S    = 2;
  localparam int F    = 3;
  localparam int PW   = 4;
  localparam int MAXP = (1 << PW) - 1;

  logic          CLK = 1'b0;
  logic          RESET, EN, A, B;
  logic          STEP, DIR, ERR, CO;
  logic [PW-1:0] POS;

  int n_cmp = 0;
  int n_bad = 0;
  int step_cnt = 0, err_cnt = 0, co_cnt = 0;

  quad_step_decoder #(.SYNC_STAGES(S), .FILT_LEN(F), .POS_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .A(A), .B(B),
    .STEP(STEP), .DIR(DIR), .ERR(ERR), .POS(POS), .CO(CO)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gray position of a pin pair along the up sequence 00,01,11,10.
  function automatic int gidx_of(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: history of raw pin samples; a level is accepted once the
  // last F synchronised samples all disagree with the accepted level.
  logic [1:0] pin_q[$];
  logic [1:0] m_acc, m_prev, s_now, cur;
  logic       m_track, m_dir, m_step, m_err, m_co, all_diff;
  logic       m_valid = 1'b0;
  int         m_cyc, m_pos, d;

  always @(posedge CLK) begin : ref_model
    if (RESET) begin
      pin_q.delete();
      for (int i = 0; i < S + F - 1; i++) pin_q.push_back(2'b00);
      m_acc = 2'b00; m_prev = 2'b00; m_cyc = 0; m_track = 1'b0;
      m_pos = 0; m_dir = 1'b1; m_step = 1'b0; m_err = 1'b0; m_co = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_step = 1'b0; m_err = 1'b0; m_co = 1'b0;
      s_now = pin_q[S-1];
      if (m_track) begin
        cur = m_acc;
        d = (gidx_of(cur) - gidx_of(m_prev) + 4) % 4;
        m_prev = cur;
        if (EN) begin
          if (d == 1) begin
            m_step = 1'b1; m_dir = 1'b1; m_co = (m_pos == MAXP);
            m_pos = (m_pos + 1) % (MAXP + 1);
          end else if (d == 3) begin
            m_step = 1'b1; m_dir = 1'b0; m_co = (m_pos == 0);
            m_pos = (m_pos + MAXP) % (MAXP + 1);
          end else if (d == 2) begin
            m_err = 1'b1;
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < F; k++)
          if (pin_q[S-1+k][c] == m_acc[c]) all_diff = 1'b0;
        if (all_diff) m_acc[c] = s_now[c];
      end
      if (!m_track) begin
        m_cyc++;
        if (m_cyc == S + F) begin
          m_acc = s_now; m_prev = s_now; m_track = 1'b1;
        end
      end
      pin_q.push_front({A, B});
      void'(pin_q.pop_back());
    end
  end

  always @(negedge CLK) begin : scoreboard
    if (m_valid) begin
      check_eq("step", STEP, m_step);
      check_eq("dir",  DIR,  m_dir);
      check_eq("err",  ERR,  m_err);
      check_eq("pos",  POS,  m_pos);
      check_eq("co",   CO,   m_co);
      if (STEP === 1'b1) step_cnt++;
      if (ERR === 1'b1)  err_cnt++;
      if (CO === 1'b1)   co_cnt++;
    end
  end

  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int gidx = 0;
  int lat;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic clear_counts();
    step_cnt = 0; err_cnt = 0; co_cnt = 0;
  endtask

  task automatic set_pins(input logic [1:0] p, input int hold);
    {A, B} = p;
    gidx = gidx_of(p);
    tick(hold);
  endtask

  task automatic up_step(input int hold);
    set_pins(seq[(gidx + 1) % 4], hold);
  endtask

  task automatic down_step(input int hold);
    set_pins(seq[(gidx + 3) % 4], hold);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    tick(n);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b1; A = 1'b1; B = 1'b1;

    // Pins at 11 across reset: quiet INIT, tracking starts from 11.
    tick(3);
    RESET = 1'b0;
    tick(20);
    check_eq("p1_step", step_cnt, 0);
    check_eq("p1_err", err_cnt, 0);
    check_eq("p1_pos", POS, 0);
    check_eq("p1_dir", DIR, 1);
    set_pins(2'b10, 10);
    check_eq("p1_from11_step", step_cnt, 1);
    check_eq("p1_from11_pos", POS, 1);

    // Up sequence with first-step latency.
    set_pins(2'b00, 0);
    do_reset(2);
    tick(20);
    clear_counts();
    {A, B} = 2'b01;
    gidx = 1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (STEP === 1'b1 && lat < 0) lat = i;
    end
    check_eq("p2_latency", lat, 6);
    up_step(10); up_step(10); up_step(10);
    check_eq("p2_steps", step_cnt, 4);
    check_eq("p2_pos", POS, 4);
    check_eq("p2_dir", DIR, 1);
    check_eq("p2_err", err_cnt, 0);

    // Wrap up through all-ones, then back down.
    clear_counts();
    repeat (11) up_step(10);
    check_eq("p3_pos15", POS, 15);
    check_eq("p3_no_co", co_cnt, 0);
    up_step(10);
    check_eq("p3_wrap_pos", POS, 0);
    check_eq("p3_wrap_co", co_cnt, 1);
    down_step(10);
    check_eq("p3_down_pos", POS, 15);
    check_eq("p3_down_co", co_cnt, 2);
    check_eq("p3_down_dir", DIR, 0);

    // Glitch on A: 2 cycles rejected, 3 cycles accepted (and the return too).
    clear_counts();
    {A, B} = {~A, B}; tick(2);
    {A, B} = {~A, B}; tick(20);
    check_eq("p4_short_step", step_cnt, 0);
    check_eq("p4_short_pos", POS, 15);
    {A, B} = {~A, B}; tick(3);
    {A, B} = {~A, B}; tick(20);
    check_eq("p4_long_step", step_cnt, 2);
    check_eq("p4_long_pos", POS, 15);
    check_eq("p4_err", err_cnt, 0);

    // Illegal 00 -> 11, then a legal step out of 11.
    set_pins(2'b00, 0);
    do_reset(2);
    tick(20);
    clear_counts();
    set_pins(2'b11, 20);
    check_eq("p5_err", err_cnt, 1);
    check_eq("p5_step", step_cnt, 0);
    check_eq("p5_pos", POS, 0);
    up_step(10);
    check_eq("p5_after_step", step_cnt, 1);
    check_eq("p5_after_pos", POS, 1);
    check_eq("p5_after_dir", DIR, 1);

    // Steps while disabled are lost.
    clear_counts();
    EN = 1'b0;
    up_step(10); up_step(10); up_step(10);
    check_eq("p6_dis_step", step_cnt, 0);
    check_eq("p6_dis_pos", POS, 1);
    check_eq("p6_dis_co", co_cnt, 0);
    EN = 1'b1;
    up_step(10);
    check_eq("p6_en_step", step_cnt, 1);
    check_eq("p6_en_pos", POS, 2);

    // Reset in the middle of a filtered edge.
    clear_counts();
    up_step(3);
    RESET = 1'b1;
    tick(1);
    check_eq("p7_rst_pos", POS, 0);
    check_eq("p7_rst_dir", DIR, 1);
    RESET = 1'b0;
    tick(20);
    check_eq("p7_after_step", step_cnt, 0);
    check_eq("p7_after_pos", POS, 0);

    // Random activity, scored by the model every cycle.
    for (int it = 0; it < 300; it++) begin
      int r;
      if ($urandom_range(0, 99) < 3) do_reset($urandom_range(1, 2));
      EN = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      if (r < 5)      up_step($urandom_range(1, 10));
      else if (r < 8) down_step($urandom_range(1, 10));
      else if (r < 9) set_pins(seq[(gidx + 2) % 4], $urandom_range(1, 10));
      else            set_pins(2'($urandom_range(0, 3)), $urandom_range(1, 10));
    end
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature (A/B) input decoder that produces the EN/DIR-style step stream a 4-bit up/down counter consumes.
- It also keeps its own wrap-around position count with a carry/borrow pulse.
- It sits between the external encoder pins and the counting datapath.
- Stages: input synchronisation, glitch filtering, Gray-sequence decoding with illegal-transition detection, and position accumulation.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per input channel (minimum 2).
- FILT_LEN, 3: consecutive cycles a synchronised level must differ from the accepted level before it is accepted (minimum 1).
- POS_W, 4: position counter width.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous reset, active-high.
- EN  input  1  decode enable.
- A  input  1  encoder channel A, asynchronous.
- B  input  1  encoder channel B, asynchronous.
- STEP  output  1  one-cycle pulse per legal quadrature step.
- DIR  output  1  direction of the last legal step (1 = up, 0 = down).
- ERR  output  1  one-cycle pulse on an illegal (two-bit) transition.
- POS  output  POS_W  accumulated position, wraps.
- CO  output  1  one-cycle pulse when POS wraps (up from all-ones, down from zero).

Behaviour:
- Single clock domain; all outputs are registered.
- Reset is synchronous and active-high. While RESET=1 at a rising edge:
  - sync flops, filter counters and accepted levels clear to 0;
  - STEP=0, ERR=0, CO=0, DIR=1, POS=0;
  - FSM goes to INIT.
- Synchroniser: each channel passes through SYNC_STAGES flops; As and Bs are the last-stage outputs.
- Filter, per channel:
  - If the sync output differs from the accepted level, the mismatch counter increments; otherwise it clears.
  - When the counter reaches FILT_LEN, the accepted level (Af/Bf) takes the new value and the counter clears.
  - A pulse shorter than FILT_LEN cycles at the sync output is never accepted.
- FSM has two states, INIT and TRACK.
  - INIT: counts SYNC_STAGES+FILT_LEN cycles after reset release. It then loads Af/Bf and prev directly from As/Bs and moves to TRACK. No STEP or ERR is produced in INIT, whatever the pin levels.
  - TRACK: each cycle, cur={Af,Bf} is compared with prev, then prev<=cur.
- Up sequence is 00->01->11->10->00; down is the reverse.
  - cur==prev: no event.
  - One-step forward: STEP=1, DIR<=1.
  - One-step backward: STEP=1, DIR<=0.
  - Both bits changed (00<->11, 01<->10): ERR=1, STEP=0, DIR and POS unchanged. Tracking resumes from the new state.
- EN=0:
  - Synchroniser, filter and prev keep tracking.
  - STEP, ERR and CO are forced 0.
  - POS and DIR hold.
  - Transitions that occur while EN=0 are lost, not queued.
- POS updates at the same edge that asserts STEP: +1 when the step is up, -1 when down, modulo 2^POS_W.
- CO asserts at that same edge when POS goes all-ones->0 (up) or 0->all-ones (down).
- Latency: a level change on A held stable is first sampled at edge 1. Af updates at edge SYNC_STAGES+FILT_LEN. STEP, POS and CO update at edge SYNC_STAGES+FILT_LEN+1 (edge 6 with defaults).
- Back-to-back legal steps, one per cycle at the accepted level, each produce their own STEP pulse; none are merged.
- Reset asserted mid-operation: the next edge applies the full reset state and returns to INIT. A partially filtered edge is discarded.

Test Plan:
- Reset then hold A=1, B=1 for 20 cycles -> no STEP and no ERR; after INIT, prev=11; POS=0, DIR=1.
- EN=1, drive up sequence 00,01,11,10,00 with each level held 10 cycles -> 4 STEP pulses with DIR=1; POS 0->4; first STEP exactly 6 edges after the A change.
- POS_W=4, preload by 15 up-steps, then 1 more up-step -> POS=0 and CO=1 for exactly one cycle. Then one down-step -> POS=15, CO=1, DIR=0.
- Glitch: A high for 2 cycles (FILT_LEN=3) then back low -> no change in Af, no STEP, POS unchanged. The same glitch held 3 cycles is accepted -> STEP.
- Illegal transition: from 00, change A and B together and hold -> ERR=1 for one cycle, STEP=0, POS unchanged. A following legal step from 11 is decoded normally.
- EN=0 during 3 legal steps, then EN=1 and 1 more step -> POS advances by 1 only; STEP/CO stay 0 while EN=0. RESET asserted mid-step -> POS=0 on the next edge and no STEP for the aborted edge.
